// File: rtl/mem_arbiter.sv
// Arbitrates one single-port memory between the fetch port and the data port.
// The data port wins ties. Each granted access runs to completion and then
// produces a one-cycle ready pulse.
module mem_arbiter #(
  parameter int ADDR_W = 10,
  parameter int LAT    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [31:0]       i_rdata,
  output logic              i_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic [31:0]       d_rdata,
  output logic              d_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              stall_if,
  output logic              stall_mem,
  output logic [15:0]       conflict_cnt
);

  typedef enum logic [1:0] {IDLE, I_ACC, D_ACC} state_t;

  localparam logic [2:0] LAT_CNT = 3'(LAT);

  state_t      state;
  logic [2:0]  cnt;
  logic        dWrite;
  logic [15:0] conflictNext;

  assign stall_if  = i_req & ~i_ready;
  assign stall_mem = d_req & ~d_ready;

  // Evaluated every cycle so the counter register is always rewritten.
  always_comb begin
    conflictNext = conflict_cnt;
    if (state == IDLE && i_req && d_req && conflict_cnt != 16'hFFFF)
      conflictNext = conflict_cnt + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= 3'd0;
      dWrite       <= 1'b0;
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      i_ready      <= 1'b0;
      d_ready      <= 1'b0;
      i_rdata      <= '0;
      d_rdata      <= '0;
      conflict_cnt <= '0;
    end else begin
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      i_ready      <= 1'b0;
      d_ready      <= 1'b0;
      conflict_cnt <= conflictNext;
      case (state)
        IDLE: begin
          if (d_req) begin
            state     <= D_ACC;
            mem_en    <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            dWrite    <= d_we;
            // A write only needs the issue cycle plus one before ready.
            cnt       <= d_we ? 3'd1 : LAT_CNT;
          end else if (i_req) begin
            state    <= I_ACC;
            mem_en   <= 1'b1;
            mem_addr <= i_addr;
            dWrite   <= 1'b0;
            cnt      <= LAT_CNT;
          end
        end
        I_ACC: begin
          // The ready cycle keeps the state so requests are not sampled then.
          if (i_ready) begin
            state <= IDLE;
          end else if (cnt == 3'd0) begin
            i_rdata <= mem_rdata;
            i_ready <= 1'b1;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        D_ACC: begin
          if (d_ready) begin
            state <= IDLE;
          end else if (cnt == 3'd0) begin
            if (!dWrite) d_rdata <= mem_rdata;
            d_ready <= 1'b1;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with LAT=2 and a small latency-accurate
// memory model. Outputs are sampled on the falling edge.
module tb_mem_arbiter;
  localparam int ADDR_W = 10;
  localparam int LAT    = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [31:0]       i_rdata;
  logic              i_ready;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic [31:0]       d_rdata;
  logic              d_ready;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              stall_if;
  logic              stall_mem;
  logic [15:0]       conflict_cnt;

  logic [31:0]       mem [0:1023];
  logic [31:0]       rdPipe [0:LAT-1];
  logic              plEn;
  logic [ADDR_W-1:0] plAddr;
  logic [31:0]       plData;

  int passed = 0;
  int total  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(ADDR_W), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem), .conflict_cnt(conflict_cnt)
  );

  // Read data appears LAT cycles after the mem_en cycle; filler marks idle slots.
  always @(posedge clk) begin
    if (plEn) mem[plAddr] <= plData;
    else if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    rdPipe[0] <= mem_en ? mem[mem_addr] : 32'hBAD0_BAD0;
    for (int k = 1; k < LAT; k++) rdPipe[k] <= rdPipe[k-1];
  end
  assign mem_rdata = rdPipe[LAT-1];

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    plAddr = a;
    plData = d;
    plEn   = 1'b1;
    tick(1);
    plEn   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; plEn = 1'b0; plAddr = '0; plData = '0;
    tick(1);
    preload(10'h004, 32'h2008_0005);
    preload(10'h008, 32'h1111_2222);
    preload(10'h010, 32'h3333_4444);
    preload(10'h030, 32'h0C0F_FEE0);

    // Reset state
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_readies", {30'd0, i_ready, d_ready}, 32'd0);
    chk("rst_mem_addr", {22'd0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_i_rdata", i_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_conflict", {16'd0, conflict_cnt}, 32'd0);

    // Fetch read: request in cycle 0, grant in cycle 1, ready in cycle 4
    rst = 1'b0; i_req = 1'b1; i_addr = 10'h004;
    tick(1);
    chk("f_mem_en_c1", {31'd0, mem_en}, 32'd1);
    chk("f_mem_addr_c1", {22'd0, mem_addr}, 32'h004);
    chk("f_mem_we_c1", {31'd0, mem_we}, 32'd0);
    chk("f_stall_if_c1", {31'd0, stall_if}, 32'd1);
    tick(1);
    chk("f_mem_en_c2", {31'd0, mem_en}, 32'd0);
    tick(1);
    chk("f_i_ready_c3", {31'd0, i_ready}, 32'd0);
    tick(1);
    chk("f_i_ready_c4", {31'd0, i_ready}, 32'd1);
    chk("f_i_rdata_c4", i_rdata, 32'h2008_0005);
    chk("f_stall_if_c4", {31'd0, stall_if}, 32'd0);
    i_req = 1'b0;
    tick(1);
    chk("f_i_ready_c5", {31'd0, i_ready}, 32'd0);
    chk("f_i_rdata_hold", i_rdata, 32'h2008_0005);

    // Conflict: both requests in IDLE cycle 5, data wins
    i_req = 1'b1; i_addr = 10'h008; d_req = 1'b1; d_we = 1'b0; d_addr = 10'h010;
    tick(1);
    chk("c_mem_en_d", {31'd0, mem_en}, 32'd1);
    chk("c_mem_addr_d", {22'd0, mem_addr}, 32'h010);
    chk("c_conflict", {16'd0, conflict_cnt}, 32'd1);
    chk("c_stalls", {30'd0, stall_if, stall_mem}, 32'd3);
    tick(3);
    chk("c_d_ready", {31'd0, d_ready}, 32'd1);
    chk("c_d_rdata", d_rdata, 32'h3333_4444);
    chk("c_no_i_ready", {31'd0, i_ready}, 32'd0);
    chk("c_stall_if_dr", {31'd0, stall_if}, 32'd1);
    d_req = 1'b0;
    tick(1);
    chk("c_idle_mem_en", {31'd0, mem_en}, 32'd0);
    chk("c_stall_if_idle", {31'd0, stall_if}, 32'd1);
    tick(1);
    chk("c_mem_en_i", {31'd0, mem_en}, 32'd1);
    chk("c_mem_addr_i", {22'd0, mem_addr}, 32'h008);
    tick(3);
    chk("c_i_ready", {31'd0, i_ready}, 32'd1);
    chk("c_i_rdata", i_rdata, 32'h1111_2222);
    chk("c_conflict_hold", {16'd0, conflict_cnt}, 32'd1);
    i_req = 1'b0;
    tick(1);

    // Write: grant cycle 16, ready cycle 18
    d_req = 1'b1; d_we = 1'b1; d_addr = 10'h020; d_wdata = 32'hDEAD_BEEF;
    tick(1);
    chk("w_en_we", {30'd0, mem_en, mem_we}, 32'd3);
    chk("w_mem_addr", {22'd0, mem_addr}, 32'h020);
    chk("w_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    tick(1);
    chk("w_en_we_off", {30'd0, mem_en, mem_we}, 32'd0);
    chk("w_d_ready_early", {31'd0, d_ready}, 32'd0);
    tick(1);
    chk("w_d_ready", {31'd0, d_ready}, 32'd1);
    chk("w_d_rdata_kept", d_rdata, 32'h3333_4444);
    chk("w_no_i_ready", {31'd0, i_ready}, 32'd0);
    chk("w_mem_model", mem[10'h020], 32'hDEAD_BEEF);
    d_req = 1'b0; d_we = 1'b0;
    tick(1);
    chk("w_d_ready_off", {31'd0, d_ready}, 32'd0);

    // Read back the written word through the data port
    d_req = 1'b1; d_addr = 10'h020;
    tick(4);
    chk("rb_d_ready", {31'd0, d_ready}, 32'd1);
    chk("rb_d_rdata", d_rdata, 32'hDEAD_BEEF);
    d_req = 1'b0;
    tick(1);

    // Dropped fetch request still completes
    i_req = 1'b1; i_addr = 10'h030;
    tick(1);
    chk("dr_mem_en", {31'd0, mem_en}, 32'd1);
    chk("dr_mem_addr", {22'd0, mem_addr}, 32'h030);
    i_req = 1'b0;
    tick(2);
    chk("dr_i_ready_early", {31'd0, i_ready}, 32'd0);
    tick(1);
    chk("dr_i_ready", {31'd0, i_ready}, 32'd1);
    chk("dr_i_rdata", i_rdata, 32'h0C0F_FEE0);
    tick(1);
    chk("dr_i_ready_off", {31'd0, i_ready}, 32'd0);
    tick(1);
    chk("dr_no_regrant", {31'd0, mem_en}, 32'd0);
    chk("dr_stall_if", {31'd0, stall_if}, 32'd0);

    // Reset one cycle after a fetch grant
    i_req = 1'b1; i_addr = 10'h008;
    tick(1);
    chk("rm_mem_en", {31'd0, mem_en}, 32'd1);
    rst = 1'b1; i_req = 1'b0;
    tick(1);
    chk("rm_mem_en0", {31'd0, mem_en}, 32'd0);
    chk("rm_mem_addr0", {22'd0, mem_addr}, 32'd0);
    chk("rm_i_rdata0", i_rdata, 32'd0);
    chk("rm_d_rdata0", d_rdata, 32'd0);
    chk("rm_mem_wdata0", mem_wdata, 32'd0);
    chk("rm_conflict0", {16'd0, conflict_cnt}, 32'd0);
    rst = 1'b0;
    for (int n = 0; n < 6; n++) begin
      tick(1);
      chk("rm_no_i_ready", {30'd0, i_ready, mem_en}, 32'd0);
    end

    // Saturation: preset the counter near the top, then keep both requesting
    force dut.conflict_cnt = 16'hFFFD;
    tick(1);
    release dut.conflict_cnt;
    chk("s_preset", {16'd0, conflict_cnt}, 32'h0000_FFFD);
    i_req = 1'b1; i_addr = 10'h004; d_req = 1'b1; d_we = 1'b1; d_addr = 10'h040;
    d_wdata = 32'h0;
    tick(1);
    chk("s_fffe", {16'd0, conflict_cnt}, 32'h0000_FFFE);
    tick(4);
    chk("s_ffff", {16'd0, conflict_cnt}, 32'h0000_FFFF);
    tick(8);
    chk("s_hold", {16'd0, conflict_cnt}, 32'h0000_FFFF);
    chk("s_fetch_starved", {31'd0, i_ready}, 32'd0);
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    tick(6);
    chk("s_after", {16'd0, conflict_cnt}, 32'h0000_FFFF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
